// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state/op encodings and default iteration counts for multdiv_ctrl
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;
  localparam int MULT_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF = 33;
endpackage

// File: rtl/multdiv_cycle_cnt.sv
// multdiv_cycle_cnt: iteration counter with sync clear/enable, flags count==limit-1
module multdiv_cycle_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (en) count <= count + 1'b1;
  assign done = count == limit - 1'b1;
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer for the shared iterative multiplier/divider pair
// MULTDIV_EARLY_EXCEPT_EN: divide-by-zero completes next cycle without running the divider
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mult_start,
  output logic        div_start,
  input  logic [31:0] mult_result,
  input  logic        mult_except,
  input  logic [31:0] div_quot,
  input  logic        div_except,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  state_t state, state_nxt;
  op_t op;
  logic dz, req, dz_req, early, done, fin;
  assign req    = ctrl_MULT | ctrl_DIV;
  assign dz_req = !ctrl_MULT && ctrl_DIV && data_operandB == 32'd0;
`ifdef MULTDIV_EARLY_EXCEPT_EN
  assign early = dz_req;
`else
  assign early = 1'b0;
`endif
  assign fin  = state == RUN && done && !req;
  assign busy = state == RUN;
  multdiv_cycle_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(reset),
    .clear(req),
    .en(state == RUN),
    .limit(op == OP_MULT ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES)),
    .done(done)
  );
  always_comb begin
    state_nxt = state;
    if (req) state_nxt = early ? DONE : RUN;
    else if (fin) state_nxt = DONE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (reset) begin
      op             <= OP_MULT;
      dz             <= 1'b0;
      op_a           <= '0;
      op_b           <= '0;
      mult_start     <= 1'b0;
      div_start      <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      mult_start     <= ctrl_MULT;
      div_start      <= !ctrl_MULT && ctrl_DIV && !early;
      data_resultRDY <= fin || early;
      if (req) begin
        op_a <= data_operandA;
        op_b <= data_operandB;
        op   <= ctrl_MULT ? OP_MULT : OP_DIV;
        dz   <= dz_req;
      end
      if (early) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end else if (fin) begin
        data_result    <= op == OP_MULT ? mult_result : (dz ? 32'd0 : div_quot);
        data_exception <= op == OP_MULT ? mult_except : (dz | div_except);
      end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed self-checking bench for multdiv_ctrl with a behavioural datapath
module tb_multdiv_ctrl;
  logic clk = 0, reset = 1, ctrl_MULT = 0, ctrl_DIV = 0;
  logic [31:0] data_operandA = 0, data_operandB = 0;
  logic [31:0] op_a, op_b, mult_result, div_quot, data_result;
  logic mult_start, div_start, mult_except, div_except, data_exception, data_resultRDY, busy;
  int checks = 0, errors = 0;

  multdiv_ctrl dut (
    .clk(clk), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .op_a(op_a), .op_b(op_b), .mult_start(mult_start), .div_start(div_start),
    .mult_result(mult_result), .mult_except(mult_except),
    .div_quot(div_quot), .div_except(div_except),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: garbage quotient on divide-by-zero so forcing to 0 is visible
  assign mult_result = op_a * op_b;
  assign mult_except = 1'b0;
  assign div_quot    = op_b != 0 ? op_a / op_b : 32'hFFFF_FFFF;
  assign div_except  = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    step();
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = 32'hDEAD_BEEF; data_operandB = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    reset = 1;
    step(); step();
    reset = 0;
    checks++;
    if ({op_a, op_b, data_result, data_exception, data_resultRDY, busy, mult_start, div_start} !== '0) begin
      errors++;
      $display("FAIL reset outputs got a=%h b=%h r=%h e=%b rdy=%b busy=%b ms=%b ds=%b exp all 0",
               op_a, op_b, data_result, data_exception, data_resultRDY, busy, mult_start, div_start);
    end
  endtask

  task automatic test_mult();
    issue(1, 0, 6, 7);
    for (int c = 1; c <= 35; c++) begin
      checks++;
      if (mult_start !== (c == 1) || div_start !== 1'b0 || busy !== (c <= 32) || data_resultRDY !== (c == 33)) begin
        errors++;
        $display("FAIL mult timing c=%0d got ms=%b ds=%b busy=%b rdy=%b", c, mult_start, div_start, busy, data_resultRDY);
      end
      if (c >= 33) begin
        checks++;
        if (data_result !== 32'd42 || data_exception !== 1'b0) begin
          errors++;
          $display("FAIL mult result c=%0d got %0d/%b exp 42/0", c, data_result, data_exception);
        end
      end
      step();
    end
  endtask

  task automatic test_div();
    issue(0, 1, 100, 7);
    for (int c = 1; c <= 37; c++) begin
      checks++;
      if (div_start !== (c == 1) || mult_start !== 1'b0 || busy !== (c <= 33) || data_resultRDY !== (c == 34)) begin
        errors++;
        $display("FAIL div timing c=%0d got ms=%b ds=%b busy=%b rdy=%b", c, mult_start, div_start, busy, data_resultRDY);
      end
      if (c >= 34) begin
        checks++;
        if (data_result !== 32'd14 || data_exception !== 1'b0) begin
          errors++;
          $display("FAIL div result c=%0d got %0d/%b exp 14/0", c, data_result, data_exception);
        end
      end
      step();
    end
  endtask

  task automatic test_div_zero();
`ifdef MULTDIV_EARLY_EXCEPT_EN
    int rdy_c = 1;
    logic ds_exp = 0;
`else
    int rdy_c = 34;
    logic ds_exp = 1;
`endif
    issue(0, 1, 5, 0);
    for (int c = 1; c <= 36; c++) begin
      checks++;
      if (div_start !== (ds_exp && c == 1) || data_resultRDY !== (c == rdy_c)) begin
        errors++;
        $display("FAIL div0 timing c=%0d got ds=%b rdy=%b", c, div_start, data_resultRDY);
      end
      if (c >= rdy_c) begin
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b1) begin
          errors++;
          $display("FAIL div0 result c=%0d got %h/%b exp 0/1", c, data_result, data_exception);
        end
      end
      step();
    end
  endtask

  task automatic test_abort();
    issue(1, 0, 11, 13);
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort pre c=%0d got rdy=%b busy=%b exp 0/1", c, data_resultRDY, busy);
      end
      step();
    end
    issue(0, 1, 9, 3);
    for (int c = 11; c <= 46; c++) begin
      checks++;
      if (div_start !== (c == 11) || mult_start !== 1'b0 || data_resultRDY !== (c == 44) || busy !== (c <= 43)) begin
        errors++;
        $display("FAIL abort timing c=%0d got ms=%b ds=%b busy=%b rdy=%b", c, mult_start, div_start, busy, data_resultRDY);
      end
      if (c == 44) begin
        checks++;
        if (data_result !== 32'd3 || data_exception !== 1'b0) begin
          errors++;
          $display("FAIL abort result got %0d/%b exp 3/0", data_result, data_exception);
        end
      end
      step();
    end
  endtask

  task automatic test_both();
    issue(1, 1, 3, 4);
    for (int c = 1; c <= 34; c++) begin
      checks++;
      if (mult_start !== (c == 1) || div_start !== 1'b0 || data_resultRDY !== (c == 33)) begin
        errors++;
        $display("FAIL both timing c=%0d got ms=%b ds=%b rdy=%b", c, mult_start, div_start, data_resultRDY);
      end
      if (c == 33) begin
        checks++;
        if (data_result !== 32'd12) begin
          errors++;
          $display("FAIL both result got %0d exp 12", data_result);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    issue(1, 0, 2, 5);
    for (int c = 1; c <= 32; c++) step();
    checks++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'd10) begin
      errors++;
      $display("FAIL b2b first got rdy=%b r=%0d exp 1/10", data_resultRDY, data_result);
    end
    issue(0, 1, 20, 4);
    for (int c = 34; c <= 68; c++) begin
      checks++;
      if (div_start !== (c == 34) || data_resultRDY !== (c == 67)) begin
        errors++;
        $display("FAIL b2b timing c=%0d got ds=%b rdy=%b", c, div_start, data_resultRDY);
      end
      if (c == 67) begin
        checks++;
        if (data_result !== 32'd5) begin
          errors++;
          $display("FAIL b2b result got %0d exp 5", data_result);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    issue(1, 0, 8, 8);
    for (int c = 1; c <= 14; c++) step();
    reset = 1;
    step();
    reset = 0;
    checks++;
    if ({op_a, op_b, data_result, data_exception, data_resultRDY, busy, mult_start, div_start} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got a=%h b=%h r=%h e=%b rdy=%b busy=%b", op_a, op_b, data_result,
               data_exception, data_resultRDY, busy);
    end
    for (int c = 16; c <= 40; c++) begin
      checks++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid idle c=%0d got rdy=%b busy=%b exp 0/0", c, data_resultRDY, busy);
      end
      step();
    end
    issue(1, 0, 3, 3);
    for (int c = 1; c <= 33; c++) begin
      checks++;
      if (data_resultRDY !== (c == 33)) begin
        errors++;
        $display("FAIL reset_mid fresh c=%0d got rdy=%b", c, data_resultRDY);
      end
      if (c == 33) begin
        checks++;
        if (data_result !== 32'd9) begin
          errors++;
          $display("FAIL reset_mid fresh result got %0d exp 9", data_result);
        end
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_abort();
    test_both();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
